fractal_sync_rx_arb: RTL and testbench

FRACTAL_SYNC_RX_ARB -- requirements
Module: fractal_sync_rx_arb

---
 rtl/fractal_sync_rx_arb_if.sv | 42 ++++
 rtl/fractal_sync_rx_arb.sv | 185 ++++++++++++++++++
 tb/tb_fractal_sync_rx_arb.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/fractal_sync_rx_arb_if.sv
// Bundle of rx-FIFO heads, downstream request channel and lock status for
// the fractal sync rx arbiter. "slave" is the arbiter view, "master" the environment view.
interface fractal_sync_rx_arb_if #(
  parameter int N_PORTS = 4,
  parameter int AGGR_W  = 8,
  parameter int ID_W    = 8
);
  localparam int IDX_W = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;

  logic [N_PORTS-1:0]        empty_i;
  logic [N_PORTS-1:0]        sync_i;
  logic [N_PORTS-1:0]        lock_i;
  logic [N_PORTS-1:0]        free_i;
  logic [N_PORTS*AGGR_W-1:0] aggr_i;
  logic [N_PORTS*ID_W-1:0]   id_i;
  logic [N_PORTS-1:0]        pop_o;

  logic                      valid_o;
  logic                      ready_i;
  logic                      sync_o;
  logic                      lock_o;
  logic                      free_o;
  logic [AGGR_W-1:0]         aggr_o;
  logic [ID_W-1:0]           id_o;
  logic [IDX_W-1:0]          src_o;

  logic                      locked_o;
  logic [IDX_W-1:0]          owner_o;
  logic                      error_free_o;

  modport slave (
    input  empty_i, sync_i, lock_i, free_i, aggr_i, id_i, ready_i,
    output pop_o, valid_o, sync_o, lock_o, free_o, aggr_o, id_o, src_o,
    output locked_o, owner_o, error_free_o
  );

  modport master (
    output empty_i, sync_i, lock_i, free_i, aggr_i, id_i, ready_i,
    input  pop_o, valid_o, sync_o, lock_o, free_o, aggr_o, id_o, src_o,
    input  locked_o, owner_o, error_free_o
  );
endinterface

// File: rtl/fractal_sync_rx_arb.sv
// Round-robin arbiter over N_PORTS fall-through rx request FIFOs with a single
// resource lock; forwards one request per cycle through a registered output stage.
module fractal_sync_rx_arb #(
  parameter int N_PORTS = 4,
  parameter int AGGR_W  = 8,
  parameter int ID_W    = 8
) (
  input logic                  clk_i,
  input logic                  rst_i,
  fractal_sync_rx_arb_if.slave bus
);
  localparam int IDX_W = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;

  typedef enum logic [0:0] {
    ST_UNLOCKED = 1'b0,
    ST_LOCKED   = 1'b1
  } lock_state_e;

  lock_state_e state_r;
  lock_state_e state_nxt_s;
  logic [IDX_W-1:0] owner_r;
  logic [IDX_W-1:0] owner_nxt_s;
  logic [IDX_W-1:0] rr_ptr_r;
  logic [IDX_W-1:0] rr_nxt_s;

  logic [N_PORTS-1:0] elig_s;
  logic [N_PORTS-1:0] pop_s;
  logic               hi_found_s;
  logic               lo_found_s;
  logic [IDX_W-1:0]   hi_idx_s;
  logic [IDX_W-1:0]   lo_idx_s;
  logic [IDX_W-1:0]   grant_idx_s;
  logic               slot_open_s;
  logic               grant_s;

  logic               g_sync_s;
  logic               g_lock_s;
  logic               g_free_s;
  logic               illegal_free_s;
  logic               fwd_s;
  logic [AGGR_W-1:0]  g_aggr_s;
  logic [ID_W-1:0]    g_id_s;

  logic               valid_r;
  logic               sync_r;
  logic               lock_r;
  logic               free_r;
  logic [AGGR_W-1:0]  aggr_r;
  logic [ID_W-1:0]    id_r;
  logic [IDX_W-1:0]   src_r;

  // Eligibility: syncs always pass; a free never waits (an illegal one is dropped on grant).
  always_comb begin
    elig_s = '0;
    for (int p = 0; p < N_PORTS; p++) begin
      elig_s[p] = ~bus.empty_i[p] &
                  (bus.sync_i[p] |
                   (state_r == ST_UNLOCKED) |
                   (owner_r == IDX_W'(p)) |
                   (bus.free_i[p] & ~bus.lock_i[p]));
    end
  end

  assign slot_open_s = ~valid_r | bus.ready_i;

  // Round-robin pick: lowest eligible index at or above rr_ptr, else lowest overall.
  always_comb begin
    hi_found_s = 1'b0;
    lo_found_s = 1'b0;
    hi_idx_s   = '0;
    lo_idx_s   = '0;
    for (int i = N_PORTS - 1; i >= 0; i--) begin
      lo_found_s = lo_found_s | elig_s[i];
      lo_idx_s   = elig_s[i] ? IDX_W'(i) : lo_idx_s;
      hi_found_s = hi_found_s | (elig_s[i] & (IDX_W'(i) >= rr_ptr_r));
      hi_idx_s   = (elig_s[i] & (IDX_W'(i) >= rr_ptr_r)) ? IDX_W'(i) : hi_idx_s;
    end
    grant_idx_s = hi_found_s ? hi_idx_s : lo_idx_s;
    grant_s     = lo_found_s & slot_open_s & ~rst_i;
  end

  // Decode the granted head: type priority sync > lock > free, and free legality.
  always_comb begin
    g_sync_s       = bus.sync_i[grant_idx_s];
    g_lock_s       = ~g_sync_s & bus.lock_i[grant_idx_s];
    g_free_s       = ~g_sync_s & ~bus.lock_i[grant_idx_s] & bus.free_i[grant_idx_s];
    g_aggr_s       = bus.aggr_i[int'(grant_idx_s) * AGGR_W +: AGGR_W];
    g_id_s         = bus.id_i[int'(grant_idx_s) * ID_W +: ID_W];
    illegal_free_s = g_free_s & ((state_r == ST_UNLOCKED) | (owner_r != grant_idx_s));
    fwd_s          = grant_s & ~illegal_free_s;
    rr_nxt_s       = (grant_idx_s == IDX_W'(N_PORTS - 1)) ? '0 : grant_idx_s + IDX_W'(1);
  end

  // One-hot pop strobe for the granted port.
  always_comb begin
    pop_s = '0;
    for (int p = 0; p < N_PORTS; p++) begin
      pop_s[p] = grant_s & (grant_idx_s == IDX_W'(p));
    end
  end

  // Lock FSM next state: only forwarded requests change ownership.
  always_comb begin
    state_nxt_s = state_r;
    owner_nxt_s = owner_r;
    case (state_r)
      ST_UNLOCKED: begin
        if (fwd_s & g_lock_s) begin
          state_nxt_s = ST_LOCKED;
          owner_nxt_s = grant_idx_s;
        end else begin
          state_nxt_s = ST_UNLOCKED;
        end
      end
      ST_LOCKED: begin
        if (fwd_s & g_free_s) begin
          state_nxt_s = ST_UNLOCKED;
        end else begin
          state_nxt_s = ST_LOCKED;
        end
      end
      default: begin
        state_nxt_s = ST_UNLOCKED;
        owner_nxt_s = '0;
      end
    endcase
  end

  // Lock FSM state and owner registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r <= ST_UNLOCKED;
      owner_r <= '0;
    end else begin
      state_r <= state_nxt_s;
      owner_r <= owner_nxt_s;
    end
  end

  // Output stage and round-robin pointer; a dropped illegal free leaves the slot empty.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_ptr_r <= '0;
      valid_r  <= 1'b0;
      sync_r   <= 1'b0;
      lock_r   <= 1'b0;
      free_r   <= 1'b0;
      aggr_r   <= '0;
      id_r     <= '0;
      src_r    <= '0;
    end else begin
      if (grant_s) begin
        rr_ptr_r <= rr_nxt_s;
      end else begin
        rr_ptr_r <= rr_ptr_r;
      end
      if (fwd_s) begin
        valid_r <= 1'b1;
        sync_r  <= g_sync_s;
        lock_r  <= g_lock_s;
        free_r  <= g_free_s;
        aggr_r  <= g_aggr_s;
        id_r    <= g_id_s;
        src_r   <= grant_idx_s;
      end else if (slot_open_s) begin
        valid_r <= 1'b0;
      end else begin
        valid_r <= valid_r;
      end
    end
  end

  assign bus.pop_o        = pop_s;
  assign bus.error_free_o = grant_s & illegal_free_s;
  assign bus.valid_o      = valid_r;
  assign bus.sync_o       = sync_r;
  assign bus.lock_o       = lock_r;
  assign bus.free_o       = free_r;
  assign bus.aggr_o       = aggr_r;
  assign bus.id_o         = id_r;
  assign bus.src_o        = src_r;
  assign bus.locked_o     = (state_r == ST_LOCKED);
  assign bus.owner_o      = owner_r;

endmodule

// File: tb/tb_fractal_sync_rx_arb.sv
// Directed per-cycle vector bench for fractal_sync_rx_arb: inputs driven at the
// falling edge, outputs compared 1 ns later against hand-computed expectations.
module tb_fractal_sync_rx_arb;
  localparam int NP = 4;
  localparam int AW = 8;
  localparam int IW = 8;
  localparam logic [2:0] T_S = 3'b100;
  localparam logic [2:0] T_L = 3'b010;
  localparam logic [2:0] T_F = 3'b001;
  localparam logic [2:0] T_N = 3'b000;

  logic clk;
  logic rst;

  fractal_sync_rx_arb_if #(.N_PORTS(NP), .AGGR_W(AW), .ID_W(IW)) bus_if ();

  fractal_sync_rx_arb #(.N_PORTS(NP), .AGGR_W(AW), .ID_W(IW)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [3:0] empty;
    logic [3:0] sync;
    logic [3:0] lock;
    logic [3:0] free;
    logic       ready;
    logic [3:0] pop;
    logic       err;
    logic       valid;
    logic [1:0] src;
    logic [2:0] typ;
    logic       locked;
    logic [1:0] owner;
  } vec_t;

  vec_t vecs[$];
  int checks = 0;
  int failures = 0;
  int row = 0;
  logic [7:0] port_id [NP];

  function automatic vec_t mk(logic r, logic [3:0] e, logic [3:0] s, logic [3:0] l,
                              logic [3:0] f, logic rdy, logic [3:0] pop, logic err,
                              logic v, logic [1:0] src, logic [2:0] typ,
                              logic lk, logic [1:0] own);
    vec_t t;
    t.rst = r; t.empty = e; t.sync = s; t.lock = l; t.free = f; t.ready = rdy;
    t.pop = pop; t.err = err; t.valid = v; t.src = src; t.typ = typ;
    t.locked = lk; t.owner = own;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s row=%0d got=0x%0h want=0x%0h", name, row, act, exp);
    end
  endtask

  task automatic drive(input vec_t t);
    rst             = t.rst;
    bus_if.empty_i  = t.empty;
    bus_if.sync_i   = t.sync;
    bus_if.lock_i   = t.lock;
    bus_if.free_i   = t.free;
    bus_if.ready_i  = t.ready;
  endtask

  initial begin
    port_id[0] = 8'h10; port_id[1] = 8'h21; port_id[2] = 8'h5A; port_id[3] = 8'h43;
    for (int p = 0; p < NP; p++) begin
      bus_if.aggr_i[p*AW +: AW] = 8'hA0 + 8'(p);
      bus_if.id_i[p*IW +: IW]   = port_id[p];
    end

    //         rst  empty    sync     lock     free    rdy  pop     err  vld  src    typ  lkd  own
    // round robin over four syncs
    vecs.push_back(mk(1'b0, 4'b0000, 4'b1111, 4'b0000, 4'b0000, 1'b1, 4'b0001, 1'b0, 1'b0, 2'd0, T_N, 1'b0, 2'd0));
    vecs.push_back(mk(1'b0, 4'b0000, 4'b1111, 4'b0000, 4'b0000, 1'b1, 4'b0010, 1'b0, 1'b1, 2'd0, T_S, 1'b0, 2'd0));
    vecs.push_back(mk(1'b0, 4'b0000, 4'b1111, 4'b0000, 4'b0000, 1'b1, 4'b0100, 1'b0, 1'b1, 2'd1, T_S, 1'b0, 2'd0));
    vecs.push_back(mk(1'b0, 4'b0000, 4'b1111, 4'b0000, 4'b0000, 1'b1, 4'b1000, 1'b0, 1'b1, 2'd2, T_S, 1'b0, 2'd0));
    vecs.push_back(mk(1'b0, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b0, 1'b1, 2'd3, T_S, 1'b0, 2'd0));
    vecs.push_back(mk(1'b0, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b0, 1'b0, 2'd0, T_N, 1'b0, 2'd0));
    // backpressure on port 2 (id 0x5A)
    vecs.push_back(mk(1'b0, 4'b1011, 4'b0100, 4'b0000, 4'b0000, 1'b0, 4'b0100, 1'b0, 1'b0, 2'd0, T_N, 1'b0, 2'd0));
    vecs.push_back(mk(1'b0, 4'b1011, 4'b0100, 4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b1, 2'd2, T_S, 1'b0, 2'd0));
    vecs.push_back(mk(1'b0, 4'b1011, 4'b0100, 4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b1, 2'd2, T_S, 1'b0, 2'd0));
    vecs.push_back(mk(1'b0, 4'b1011, 4'b0100, 4'b0000, 4'b0000, 1'b1, 4'b0100, 1'b0, 1'b1, 2'd2, T_S, 1'b0, 2'd0));
    vecs.push_back(mk(1'b0, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b0, 1'b1, 2'd2, T_S, 1'b0, 2'd0));
    vecs.push_back(mk(1'b0, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b0, 1'b0, 2'd0, T_N, 1'b0, 2'd0));
    // lock by port 1, port 3 waits, port 0 sync passes, owner free, port 3 lock
    vecs.push_back(mk(1'b0, 4'b1101, 4'b0000, 4'b0010, 4'b0000, 1'b1, 4'b0010, 1'b0, 1'b0, 2'd0, T_N, 1'b0, 2'd0));
    vecs.push_back(mk(1'b0, 4'b0110, 4'b0001, 4'b1000, 4'b0000, 1'b1, 4'b0001, 1'b0, 1'b1, 2'd1, T_L, 1'b1, 2'd1));
    vecs.push_back(mk(1'b0, 4'b0101, 4'b0000, 4'b1000, 4'b0010, 1'b1, 4'b0010, 1'b0, 1'b1, 2'd0, T_S, 1'b1, 2'd1));
    vecs.push_back(mk(1'b0, 4'b0111, 4'b0000, 4'b1000, 4'b0000, 1'b1, 4'b1000, 1'b0, 1'b1, 2'd1, T_F, 1'b0, 2'd1));
    // non-owner free while locked is dropped, owner relock is forwarded
    vecs.push_back(mk(1'b0, 4'b0110, 4'b0000, 4'b1000, 4'b0001, 1'b1, 4'b0001, 1'b1, 1'b1, 2'd3, T_L, 1'b1, 2'd3));
    vecs.push_back(mk(1'b0, 4'b0111, 4'b0000, 4'b1000, 4'b0000, 1'b1, 4'b1000, 1'b0, 1'b0, 2'd0, T_N, 1'b1, 2'd3));
    // reset while locked with a held request
    vecs.push_back(mk(1'b1, 4'b0110, 4'b0001, 4'b1000, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b1, 2'd3, T_L, 1'b1, 2'd3));
    vecs.push_back(mk(1'b0, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 2'd0, T_N, 1'b0, 2'd0));
    vecs.push_back(mk(1'b0, 4'b0000, 4'b1111, 4'b0000, 4'b0000, 1'b1, 4'b0001, 1'b0, 1'b0, 2'd0, T_N, 1'b0, 2'd0));
    vecs.push_back(mk(1'b0, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b0, 1'b1, 2'd0, T_S, 1'b0, 2'd0));
    // illegal free while unlocked
    vecs.push_back(mk(1'b0, 4'b1011, 4'b0000, 4'b0000, 4'b0100, 1'b1, 4'b0100, 1'b1, 1'b0, 2'd0, T_N, 1'b0, 2'd0));
    vecs.push_back(mk(1'b0, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b0, 1'b0, 2'd0, T_N, 1'b0, 2'd0));
    // multi-bit type priority
    vecs.push_back(mk(1'b0, 4'b1110, 4'b0001, 4'b0001, 4'b0001, 1'b1, 4'b0001, 1'b0, 1'b0, 2'd0, T_N, 1'b0, 2'd0));
    vecs.push_back(mk(1'b0, 4'b1101, 4'b0000, 4'b0010, 4'b0010, 1'b1, 4'b0010, 1'b0, 1'b1, 2'd0, T_S, 1'b0, 2'd0));
    vecs.push_back(mk(1'b0, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b0, 1'b1, 2'd1, T_L, 1'b1, 2'd1));
    vecs.push_back(mk(1'b0, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b0, 1'b0, 2'd0, T_N, 1'b1, 2'd1));

    // Power-on reset with requests pending: no pops while reset is high.
    rst = 1'b1;
    bus_if.empty_i = 4'b0000;
    bus_if.sync_i  = 4'b1111;
    bus_if.lock_i  = 4'b0000;
    bus_if.free_i  = 4'b0000;
    bus_if.ready_i = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    chk("pop_in_reset", 32'(bus_if.pop_o), 32'h0);
    chk("err_in_reset", 32'(bus_if.error_free_o), 32'h0);
    rst = 1'b0;
    bus_if.empty_i = 4'b1111;
    bus_if.sync_i  = 4'b0000;
    #1;
    chk("rst_valid", 32'(bus_if.valid_o), 32'h0);
    chk("rst_type", 32'({bus_if.sync_o, bus_if.lock_o, bus_if.free_o}), 32'h0);
    chk("rst_aggr", 32'(bus_if.aggr_o), 32'h0);
    chk("rst_id", 32'(bus_if.id_o), 32'h0);
    chk("rst_src", 32'(bus_if.src_o), 32'h0);
    chk("rst_locked", 32'(bus_if.locked_o), 32'h0);
    chk("rst_owner", 32'(bus_if.owner_o), 32'h0);

    for (int k = 0; k < vecs.size(); k++) begin
      @(negedge clk);
      row = k + 1;
      drive(vecs[k]);
      #1;
      chk("pop", 32'(bus_if.pop_o), 32'(vecs[k].pop));
      chk("error_free", 32'(bus_if.error_free_o), 32'(vecs[k].err));
      chk("valid", 32'(bus_if.valid_o), 32'(vecs[k].valid));
      chk("locked", 32'(bus_if.locked_o), 32'(vecs[k].locked));
      chk("owner", 32'(bus_if.owner_o), 32'(vecs[k].owner));
      if (vecs[k].valid) begin
        chk("src", 32'(bus_if.src_o), 32'(vecs[k].src));
        chk("type", 32'({bus_if.sync_o, bus_if.lock_o, bus_if.free_o}), 32'(vecs[k].typ));
        chk("id", 32'(bus_if.id_o), 32'(port_id[vecs[k].src]));
        chk("aggr", 32'(bus_if.aggr_o), 32'(8'hA0 + 8'(vecs[k].src)));
      end
    end

    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
